// File: rtl/i_mem_fill_rsp_if.sv
`default_nettype none
// ============================================================================
// Module      : i_mem_fill_rsp_if
// Description : Cache-line fill request/response bundle between IFU cache
//               (master) and instruction-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface i_mem_fill_rsp_if;

    typedef struct packed {
        logic        fill_requested_address_valid;
        logic [31:0] fill_requested_address;
    } t_cache2i_mem_req;

    typedef struct packed {
        logic         valid;
        logic [27:0]  address;
        logic [127:0] filled_instruction;
    } t_i_mem2cache_rsp;

    t_cache2i_mem_req cache2i_mem_req;
    t_i_mem2cache_rsp i_mem2cache_rsp;

    modport master (output cache2i_mem_req, input  i_mem2cache_rsp);
    modport slave  (input  cache2i_mem_req, output i_mem2cache_rsp);

endinterface
`default_nettype wire

// File: rtl/i_mem_fill_rsp.sv
`default_nettype none
// ============================================================================
// Module      : i_mem_fill_rsp
// Description : Instruction-memory responder; reads four words per fill
//               request and returns one registered 128-bit line plus tag.
// Revision    : 1.0 - initial release
// ============================================================================
module i_mem_fill_rsp #(
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_CYCLES = 2,
    parameter int CL_WIDTH    = 128
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    i_mem_fill_rsp_if.slave  bus,
    input  wire logic        wr_en,
    input  wire logic [31:0] wr_addr,
    input  wire logic [31:0] wr_data,
    output logic             busy,
    output logic             req_drop
);

    localparam int AW  = $clog2(MEM_WORDS);
    localparam int WCW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam logic [WCW-1:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? WCW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_READ = 2'd2,
        S_RESP = 2'd3
    } t_state;

    t_state                r_state;
    logic [27:0]           r_tag;
    logic [1:0]            r_beat;
    logic [WCW-1:0]        r_wait;
    logic [CL_WIDTH-1:0]   r_line;
    logic                  r_rsp_valid;
    logic [27:0]           r_rsp_address;
    logic [CL_WIDTH-1:0]   r_rsp_line;
    logic                  r_req_drop;
    logic [31:0]           r_mem [MEM_WORDS];

    logic                  w_req_valid;
    logic [31:0]           w_req_addr;
    logic [29:0]           w_rd_full;
    logic [AW-1:0]         w_rd_idx;
    logic [AW-1:0]         w_wr_idx;
    logic [31:0]           w_rd_data;
    logic [CL_WIDTH-1:0]   w_line_next;
    logic                  w_unused;

    assign w_req_valid = bus.cache2i_mem_req.fill_requested_address_valid;
    assign w_req_addr  = bus.cache2i_mem_req.fill_requested_address;

    // Word index wraps on the low address bits; out-of-range requests alias.
    assign w_rd_full   = {r_tag, r_beat};
    assign w_rd_idx    = w_rd_full[AW-1:0];
    assign w_wr_idx    = wr_addr[AW+1:2];
    assign w_rd_data   = r_mem[w_rd_idx];
    assign w_line_next = {w_rd_data, r_line[CL_WIDTH-1:32]};

    assign w_unused = &{1'b0, wr_addr[1:0], wr_addr[31:AW+2], w_req_addr[3:0], w_rd_full[29:AW]};

    // Array is not reset; write lands after any same-edge beat read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tag         <= '0;
            r_beat        <= '0;
            r_wait        <= '0;
            r_line        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_address <= '0;
            r_rsp_line    <= '0;
            r_req_drop    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_valid) begin
                        r_tag   <= w_req_addr[31:4];
                        r_beat  <= '0;
                        r_wait  <= c_WAIT_LOAD;
                        r_state <= (WAIT_CYCLES == 0) ? S_READ : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= S_READ;
                    end else begin
                        r_wait <= r_wait - WCW'(1);
                    end
                end
                S_READ: begin
                    // Shifting in from the top leaves beat k at bits [32k+31:32k].
                    r_line <= w_line_next;
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_state       <= S_RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_address <= r_tag;
                        r_rsp_line    <= w_line_next;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if ((r_state != S_IDLE) && w_req_valid) begin
                r_req_drop <= 1'b1;
            end
        end
    end

    assign bus.i_mem2cache_rsp = {r_rsp_valid, r_rsp_address, r_rsp_line};
    assign busy     = (r_state != S_IDLE);
    assign req_drop = r_req_drop;

endmodule
`default_nettype wire
